// File: rtl/mux_nxw_skid_pkg.sv
// rtl/mux_nxw_skid_pkg.sv - shared operand-select constants and width helper
//
// Contents:
//   WORD_W  : datapath word width
//   opsel_e : operand-source encodings used by the CPU datapath
//   sel_w() : select width for an n-way mux, never narrower than 1 bit
package mux_nxw_skid_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SEL_RF      = 2'd0,
        SEL_IMM     = 2'd1,
        SEL_FWD_EX  = 2'd2,
        SEL_FWD_MEM = 2'd3
    } opsel_e;

    // max(1, clog2(n)): a 1-input or 2-input mux still needs one select bit.
    function automatic int sel_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nxw_skid_if.sv
// rtl/mux_nxw_skid_if.sv - handshake bundle between operand sources and the selector
//
// Signals:
//   in_data   NUM_IN*WIDTH  flattened operands, operand i at [i*WIDTH +: WIDTH]
//   in_sel    SEL_W         binary select
//   in_valid  1             upstream offers in_data/in_sel
//   in_ready  1             selector can accept this cycle
//   out_data  WIDTH         selected value
//   out_sel   SEL_W         select that produced out_data
//   out_err   1             captured select was out of range
//   out_valid 1             out_* are valid
//   out_ready 1             downstream accepts
// Modports: master = upstream/downstream side, slave = selector side.
interface mux_nxw_skid_if
    import mux_nxw_skid_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = sel_w(NUM_IN)
) ();

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_err;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_err, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_err, out_valid
    );

endinterface

// File: rtl/mux_nxw_comb.sv
// rtl/mux_nxw_comb.sv - purely combinational N-way select with default/err output
//
// Ports:
//   in_data  input   NUM_IN*WIDTH  flattened operands, operand i at [i*WIDTH +: WIDTH]
//   sel      input   SEL_W         binary select
//   data     output  WIDTH         selected operand, or DEFAULT_VAL when sel >= NUM_IN
//   err      output  1             sel >= NUM_IN
module mux_nxw_comb
    import mux_nxw_skid_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          NUM_IN      = 4,
    parameter logic [31:0] DEFAULT_VAL = 32'h0000_0000,
    localparam int         SEL_W       = sel_w(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data,
    output logic                    err
);

    // Unsigned cast zero-extends or truncates the 32-bit default to WIDTH.
    localparam logic [WIDTH-1:0] DEF_W = WIDTH'(DEFAULT_VAL);

    // Matching against each legal index keeps every part-select in range,
    // so unused select codes fall through to the default without an
    // out-of-bounds read.
    always_comb begin
        data = DEF_W;
        err  = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                data = in_data[i*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_nxw_skid.sv
// rtl/mux_nxw_skid.sv - N-way operand selector with registered output and 2-entry skid
//
// Ports:
//   clk    input  rising-edge clock
//   rst_n  input  asynchronous active-low reset
//   bus    slave  mux_nxw_skid_if: in_data/in_sel/in_valid/in_ready upstream,
//                 out_data/out_sel/out_err/out_valid/out_ready downstream
module mux_nxw_skid
    import mux_nxw_skid_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          NUM_IN      = 4,
    parameter logic [31:0] DEFAULT_VAL = 32'h0000_0000,
    localparam int         SEL_W       = sel_w(NUM_IN)
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_nxw_skid_if.slave  bus
);

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic [SEL_W-1:0] main_sel;
    logic             main_err;

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_sel;
    logic             skid_err;

    logic [WIDTH-1:0] new_data;
    logic             new_err;
    logic             accept;
    logic             emit;

    // Select is resolved once, on the accept cycle, and only the result is stored.
    mux_nxw_comb #(
        .WIDTH       (WIDTH),
        .NUM_IN      (NUM_IN),
        .DEFAULT_VAL (DEFAULT_VAL)
    ) u_sel (
        .in_data (bus.in_data),
        .sel     (bus.in_sel),
        .data    (new_data),
        .err     (new_err)
    );

    // in_ready comes straight from the skid flop, so out_ready never
    // reaches it combinationally.
    assign accept = bus.in_valid && !skid_valid;
    assign emit   = main_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_sel   <= '0;
            main_err   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_sel   <= '0;
            skid_err   <= 1'b0;
        end else begin
            if ((!main_valid || emit) && !skid_valid && accept) begin
                // Main free this edge: new entry goes straight to the output.
                main_valid <= 1'b1;
                main_data  <= new_data;
                main_sel   <= bus.in_sel;
                main_err   <= new_err;
            end else if (emit && skid_valid) begin
                // Drain the skid into main; in_ready was low so nothing new arrives.
                main_data  <= skid_data;
                main_sel   <= skid_sel;
                main_err   <= skid_err;
                skid_valid <= 1'b0;
            end else if (main_valid && !emit && accept) begin
                // Output stalled: park the new entry in the skid.
                skid_valid <= 1'b1;
                skid_data  <= new_data;
                skid_sel   <= bus.in_sel;
                skid_err   <= new_err;
            end else if (emit && !accept && !skid_valid) begin
                main_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = !skid_valid;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign bus.out_sel   = main_sel;
    assign bus.out_err   = main_err;

endmodule

// File: tb/tb_mux_nxw_skid.sv
// tb/tb_mux_nxw_skid.sv - self-checking bench for mux_nxw_skid over four parameter sets
module tb_mux_nxw_skid;
    import mux_nxw_skid_pkg::*;

    // Instance configs: 0 = 32b x4, 1 = 32b x3 with default, 2 = 8b x2, 3 = 64b x16
    localparam int          NI = 4;
    localparam int          W_T   [NI] = '{32, 32, 8, 64};
    localparam int          N_T   [NI] = '{4, 3, 2, 16};
    localparam int          SW_T  [NI] = '{2, 2, 1, 4};
    localparam logic [63:0] DEF_T [NI] = '{64'h0, 64'hFFFF_0000, 64'h0, 64'h0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1023:0] drv_data  [NI];
    logic [3:0]    drv_sel   [NI];
    logic          drv_valid [NI];
    logic          drv_ready [NI];

    logic [63:0]   o_data  [NI];
    logic [3:0]    o_sel   [NI];
    logic          o_err   [NI];
    logic          o_valid [NI];
    logic          o_inrdy [NI];

    mux_nxw_skid_if #(.WIDTH(WORD_W), .NUM_IN(4))  b0 ();
    mux_nxw_skid_if #(.WIDTH(WORD_W), .NUM_IN(3))  b1 ();
    mux_nxw_skid_if #(.WIDTH(8),      .NUM_IN(2))  b2 ();
    mux_nxw_skid_if #(.WIDTH(64),     .NUM_IN(16)) b3 ();

    mux_nxw_skid #(.WIDTH(WORD_W), .NUM_IN(4), .DEFAULT_VAL(32'h0000_0000))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    mux_nxw_skid #(.WIDTH(WORD_W), .NUM_IN(3), .DEFAULT_VAL(32'hFFFF_0000))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    mux_nxw_skid #(.WIDTH(8), .NUM_IN(2), .DEFAULT_VAL(32'h0000_0000))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    mux_nxw_skid #(.WIDTH(64), .NUM_IN(16), .DEFAULT_VAL(32'h0000_0000))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    assign b0.in_data = drv_data[0][127:0];
    assign b1.in_data = drv_data[1][95:0];
    assign b2.in_data = drv_data[2][15:0];
    assign b3.in_data = drv_data[3];
    assign b0.in_sel  = drv_sel[0][1:0];
    assign b1.in_sel  = drv_sel[1][1:0];
    assign b2.in_sel  = drv_sel[2][0:0];
    assign b3.in_sel  = drv_sel[3];
    assign b0.in_valid = drv_valid[0];
    assign b1.in_valid = drv_valid[1];
    assign b2.in_valid = drv_valid[2];
    assign b3.in_valid = drv_valid[3];
    assign b0.out_ready = drv_ready[0];
    assign b1.out_ready = drv_ready[1];
    assign b2.out_ready = drv_ready[2];
    assign b3.out_ready = drv_ready[3];

    assign o_data[0] = 64'(b0.out_data);
    assign o_data[1] = 64'(b1.out_data);
    assign o_data[2] = 64'(b2.out_data);
    assign o_data[3] = b3.out_data;
    assign o_sel[0]  = 4'(b0.out_sel);
    assign o_sel[1]  = 4'(b1.out_sel);
    assign o_sel[2]  = 4'(b2.out_sel);
    assign o_sel[3]  = b3.out_sel;
    assign o_err[0]  = b0.out_err;
    assign o_err[1]  = b1.out_err;
    assign o_err[2]  = b2.out_err;
    assign o_err[3]  = b3.out_err;
    assign o_valid[0] = b0.out_valid;
    assign o_valid[1] = b1.out_valid;
    assign o_valid[2] = b2.out_valid;
    assign o_valid[3] = b3.out_valid;
    assign o_inrdy[0] = b0.in_ready;
    assign o_inrdy[1] = b1.in_ready;
    assign o_inrdy[2] = b2.in_ready;
    assign o_inrdy[3] = b3.in_ready;

    // Reference model: each instance is a 2-deep FIFO of selected results.
    logic [63:0] q_data [NI][16];
    logic [3:0]  q_sel  [NI][16];
    logic        q_err  [NI][16];
    int          rd [NI];
    int          wr [NI];

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wmask(input int k);
        return (W_T[k] == 64) ? '1 : ((64'd1 << W_T[k]) - 64'd1);
    endfunction

    function automatic int occ(input int k);
        return wr[k] - rd[k];
    endfunction

    task automatic push_expected(input int k);
        int          s;
        int          p;
        s = int'(drv_sel[k]) & ((1 << SW_T[k]) - 1);
        p = wr[k] % 16;
        q_sel[k][p] = 4'(s);
        if (s < N_T[k]) begin
            q_data[k][p] = 64'(drv_data[k] >> (s * W_T[k])) & wmask(k);
            q_err[k][p]  = 1'b0;
        end else begin
            q_data[k][p] = DEF_T[k] & wmask(k);
            q_err[k][p]  = 1'b1;
        end
        wr[k]++;
    endtask

    task automatic check_model(input int k);
        int p;
        chk($sformatf("i%0d_in_ready", k), 64'(o_inrdy[k]), 64'(occ(k) < 2));
        chk($sformatf("i%0d_out_valid", k), 64'(o_valid[k]), 64'(occ(k) > 0));
        if (occ(k) > 0) begin
            p = rd[k] % 16;
            chk($sformatf("i%0d_out_data", k), o_data[k], q_data[k][p]);
            chk($sformatf("i%0d_out_sel", k), 64'(o_sel[k]), 64'(q_sel[k][p]));
            chk($sformatf("i%0d_out_err", k), 64'(o_err[k]), 64'(q_err[k][p]));
        end
    endtask

    // Commit the transfers implied by the current drives, advance one cycle,
    // then compare every instance against the model.
    task automatic step();
        for (int k = 0; k < NI; k++) begin
            if (rst_n) begin
                logic acc;
                logic emt;
                acc = drv_valid[k] && (occ(k) < 2);
                emt = drv_ready[k] && (occ(k) > 0);
                if (emt) rd[k]++;
                if (acc) push_expected(k);
            end
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) check_model(k);
    endtask

    task automatic load(input int k, input int sel, input logic [63:0] word);
        logic [1023:0] hole;
        for (int j = 0; j < 32; j++) drv_data[k][j*32 +: 32] = $urandom();
        hole = 1024'(wmask(k)) << (sel * W_T[k]);
        drv_data[k] = (drv_data[k] & ~hole) | (1024'(word & wmask(k)) << (sel * W_T[k]));
        drv_sel[k] = 4'(sel);
    endtask

    task automatic send(input int k, input int sel, input logic [63:0] word);
        load(k, sel, word);
        drv_valid[k] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] w;
        for (int k = 0; k < NI; k++) begin
            drv_data[k] = '0;
            drv_sel[k] = '0;
            drv_valid[k] = 1'b0;
            drv_ready[k] = 1'b0;
            rd[k] = 0;
            wr[k] = 0;
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(o_valid[0]), 64'd0);
        chk("rst_in_ready", 64'(o_inrdy[0]), 64'd1);
        chk("rst_out_data", o_data[0], 64'd0);
        chk("rst_out_sel", 64'(o_sel[0]), 64'd0);
        chk("rst_out_err", 64'(o_err[0]), 64'd0);
        for (int k = 0; k < NI; k++) check_model(k);
        rst_n = 1'b1;

        // Fill both entries, then reset asynchronously mid-cycle
        send(0, 0, 64'hAA);
        step();
        send(0, 1, 64'hBB);
        step();
        chk("full_in_ready", 64'(o_inrdy[0]), 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(o_valid[0]), 64'd0);
        chk("midrst_in_ready", 64'(o_inrdy[0]), 64'd1);
        chk("midrst_out_data", o_data[0], 64'd0);
        for (int k = 0; k < NI; k++) begin
            rd[k] = 0;
            wr[k] = 0;
        end
        drv_valid[0] = 1'b0;
        step();
        rst_n = 1'b1;
        send(0, int'(SEL_FWD_EX), 64'hDEAD_BEEF);
        drv_ready[0] = 1'b1;
        step();
        chk("first_out_data", o_data[0], 64'hDEAD_BEEF);
        chk("first_out_sel", 64'(o_sel[0]), 64'd2);
        drv_valid[0] = 1'b0;
        step();

        // Streaming, 1-cycle latency, in_ready never drops
        for (int i = 0; i < 8; i++) begin
            send(0, i % 4, 64'h1000_0000 + 64'(i));
            step();
            chk("stream_data", o_data[0], 64'h1000_0000 + 64'(i));
            chk("stream_in_ready", 64'(o_inrdy[0]), 64'd1);
        end
        drv_valid[0] = 1'b0;
        step();

        // Backpressure: A held, B in skid, C held upstream
        drv_ready[0] = 1'b0;
        send(0, 0, 64'hAA);
        step();
        send(0, 1, 64'hBB);
        step();
        chk("bp_hold_a", o_data[0], 64'hAA);
        chk("bp_in_ready_lo", 64'(o_inrdy[0]), 64'd0);
        send(0, 2, 64'hCC);
        step();
        chk("bp_still_a", o_data[0], 64'hAA);
        drv_ready[0] = 1'b1;
        step();
        chk("bp_b_out", o_data[0], 64'hBB);
        chk("bp_in_ready_hi", 64'(o_inrdy[0]), 64'd1);
        step();
        chk("bp_c_out", o_data[0], 64'hCC);
        drv_valid[0] = 1'b0;
        step();
        chk("bp_drained", 64'(o_valid[0]), 64'd0);

        // Out-of-range select on the 3-input instance
        drv_ready[1] = 1'b1;
        send(1, 3, 64'h0);
        step();
        chk("oor_data", o_data[1], 64'hFFFF_0000);
        chk("oor_err", 64'(o_err[1]), 64'd1);
        send(1, 1, 64'h1234_5678);
        step();
        chk("inr_data", o_data[1], 64'h1234_5678);
        chk("inr_err", 64'(o_err[1]), 64'd0);
        drv_valid[1] = 1'b0;
        step();

        // Simultaneous accept and emit: output refreshes every cycle, skid stays empty
        drv_ready[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w = 64'($urandom());
            send(0, i % 4, w);
            step();
            chk("sim_data", o_data[0], w);
            chk("sim_valid", 64'(o_valid[0]), 64'd1);
            chk("sim_in_ready", 64'(o_inrdy[0]), 64'd1);
        end
        drv_valid[0] = 1'b0;
        step();

        // Randomized valid/ready on all four parameter sets
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < NI; k++) begin
                load(k, int'($urandom_range(0, 15)), {$urandom(), $urandom()});
                drv_sel[k] = 4'($urandom_range(0, 15));
                drv_valid[k] = ($urandom_range(0, 3) != 0);
                drv_ready[k] = ($urandom_range(0, 2) != 0);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
